// File: rtl/fetch_unit.sv
// Instruction fetch stage for the LEGv8 pipeline: owns the fetch PC, drives a
// one-cycle-latency instruction memory and buffers returned words for decode.
module fetch_unit #(
  parameter int              WORD      = 64,
  parameter int              INSTR_LEN = 32,
  parameter logic [WORD-1:0] RESET_PC  = '0
) (
  input  logic                 write_clk,
  input  logic                 reset_n,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  input  logic                 redirect,
  input  logic [WORD-1:0]      redirect_pc,
  input  logic                 dec_ready,
  output logic                 instr_valid,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      cur_pc_out
);

  logic [WORD-1:0]      fetch_pc_q, fetch_pc_d;
  logic                 run_q, run_d;
  logic                 inflight_q, inflight_d;
  logic [WORD-1:0]      inflight_pc_q, inflight_pc_d;
  logic                 squash_q, squash_d;
  logic [1:0]           count_q, count_d;
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [INSTR_LEN-1:0] q_instr_q [2];
  logic [INSTR_LEN-1:0] q_instr_d [2];
  logic [WORD-1:0]      q_pc_q [2];
  logic [WORD-1:0]      q_pc_d [2];
  logic [INSTR_LEN-1:0] last_instr_q, last_instr_d;
  logic [WORD-1:0]      last_pc_q, last_pc_d;

  logic       pop;
  logic       push;
  logic [2:0] occupancy;

  // Head view falls back to the last presented entry so outputs hold when empty.
  always_comb begin
    instr_valid = (count_q != 2'd0);
    instruction = instr_valid ? q_instr_q[head_q] : last_instr_q;
    cur_pc_out  = instr_valid ? q_pc_q[head_q] : last_pc_q;
    imem_addr   = fetch_pc_q;
    pop         = instr_valid & dec_ready;
    push        = inflight_q & ~squash_q & ~redirect;
    occupancy   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    imem_req    = run_q & ~redirect & (occupancy < 3'd2);
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    run_d         = 1'b1;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    squash_d      = squash_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    q_instr_d     = q_instr_q;
    q_pc_d        = q_pc_q;
    last_instr_d  = instruction;
    last_pc_d     = cur_pc_out;

    if (redirect) begin
      // Flush everything, including the return arriving this very cycle.
      count_d    = 2'd0;
      head_d     = 1'b0;
      tail_d     = 1'b0;
      squash_d   = 1'b0;
      fetch_pc_d = redirect_pc & ~WORD'(3);
    end else begin
      if (push) begin
        q_instr_d[tail_q] = imem_rdata;
        q_pc_d[tail_q]    = inflight_pc_q;
        tail_d            = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + WORD'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge write_clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      run_q         <= 1'b0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
      tail_q        <= 1'b0;
      last_instr_q  <= '0;
      last_pc_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      run_q         <= run_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      squash_q      <= squash_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      last_instr_q  <= last_instr_d;
      last_pc_q     <= last_pc_d;
      for (int i = 0; i < 2; i++) begin
        q_instr_q[i] <= q_instr_d[i];
        q_pc_q[i]    <= q_pc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        write_clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        dec_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [63:0] cur_pc_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  fetch_unit #(.WORD(64), .INSTR_LEN(32), .RESET_PC(RESET_PC)) dut (
    .write_clk  (write_clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .dec_ready  (dec_ready),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .cur_pc_out (cur_pc_out)
  );

  always #5 write_clk = ~write_clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } entry_t;

  // Reference model: fetched-but-not-consumed words as a plain queue.
  entry_t      mq[$];
  bit          m_run;
  bit          m_infl;
  logic [63:0] m_infl_pc;
  logic [63:0] m_fpc;
  logic [63:0] m_last_pc;
  logic [31:0] m_last_ins;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h8B00_0000 + a[31:0];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_run      = 1'b0;
    m_infl     = 1'b0;
    m_infl_pc  = '0;
    m_fpc      = RESET_PC;
    m_last_pc  = '0;
    m_last_ins = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(instr_valid), 64'd0);
    check_eq({tag, "_req"},   64'(imem_req),    64'd0);
    check_eq({tag, "_addr"},  imem_addr,        RESET_PC);
    check_eq({tag, "_ins"},   64'(instruction), 64'd0);
    check_eq({tag, "_pc"},    cur_pc_out,       64'd0);
  endtask

  // One clock cycle: drive, check against the model, advance model, answer memory.
  task automatic step(input bit dr, input bit rd, input logic [63:0] rpc);
    bit          exp_valid, exp_req, pop;
    logic [63:0] exp_pc;
    logic [31:0] exp_ins;
    int          occ;
    logic        req_s;
    logic [63:0] addr_s;
    @(negedge write_clk);
    dec_ready   = dr;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    exp_valid = (mq.size() != 0);
    exp_pc    = exp_valid ? mq[0].pc  : m_last_pc;
    exp_ins   = exp_valid ? mq[0].ins : m_last_ins;
    pop       = exp_valid && dr;
    occ       = mq.size() + int'(m_infl) - int'(pop);
    exp_req   = m_run && !rd && (occ < 2);
    check_eq("valid", 64'(instr_valid), 64'(exp_valid));
    check_eq("req",   64'(imem_req),    64'(exp_req));
    check_eq("addr",  imem_addr,        m_fpc);
    check_eq("ins",   64'(instruction), 64'(exp_ins));
    check_eq("pc",    cur_pc_out,       exp_pc);
    if (pop)
      $display("cyc %0d deliver pc=%h ins=%h", n_cyc, cur_pc_out, instruction);
    m_last_pc  = exp_pc;
    m_last_ins = exp_ins;
    if (rd) begin
      mq.delete();
      m_infl = 1'b0;
      m_fpc  = rpc & ~64'h3;
    end else begin
      if (m_infl) mq.push_back('{pc: m_infl_pc, ins: mem_word(m_infl_pc)});
      if (pop) void'(mq.pop_front());
      if (exp_req) begin
        m_infl    = 1'b1;
        m_infl_pc = m_fpc;
        m_fpc     = m_fpc + 64'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    m_run  = 1'b1;
    req_s  = imem_req;
    addr_s = imem_addr;
    @(posedge write_clk);
    #1;
    imem_rdata = req_s ? mem_word(addr_s) : 32'h0BAD_0BAD;
    n_cyc++;
  endtask

  // Asynchronous reset between edges, then release shortly after a rising edge.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    repeat (2) @(posedge write_clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    dec_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rdata  = '0;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(posedge write_clk);
    #2;
    reset_n = 1'b1;

    // Reset start: stream until head reaches 0x10, then stall 5 cycles.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0);
    check_eq("head_0x10", cur_pc_out, 64'h10);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 40 && !(mq.size() != 0 && mq[0].pc == 64'h20); i++)
      step(1'b1, 1'b0, '0);

    // Redirect while the queue is occupied, target with low bits set.
    step(1'b0, 1'b1, 64'h103);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Redirect coinciding with a pop.
    step(1'b1, 1'b1, 64'h200);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);

    // Wrap-around of the fetch PC.
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Back-to-back redirects: the second one wins.
    step(1'b1, 1'b1, 64'h300);
    step(1'b1, 1'b1, 64'h404);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Asynchronous reset mid-stream and restart from RESET_PC.
    async_reset("arst");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

    // Random traffic with occasional redirects and one more reset.
    for (int i = 0; i < 1500; i++) begin
      bit          dr, rd;
      logic [63:0] rpc;
      dr  = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      step(dr, rd, rpc);
      if (i == 700) async_reset("arst2");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
